// File: rtl/accumulator_pkg.sv
// Shared types and sizing helper for the nibble-serial multi-lane accumulator.
package accumulator_pkg;

    typedef enum logic [1:0] {
        ACCUM      = 2'b00,
        READ_CLEAR = 2'b01,
        READ_KEEP  = 2'b10,
        CLEAR      = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RECV = 2'b01,
        SEND = 2'b10,
        DONE = 2'b11
    } state_t;

    // Accumulator width: operand width plus lane-growth bits plus headroom.
    function automatic int acc_width(int bit_width, int num_inputs, int guard);
        return bit_width + $clog2(num_inputs) + guard;
    endfunction

endpackage

// File: rtl/nibble_lane_adder.sv
// Combinational sum of NUM_INPUTS 4-bit lane nibbles.
module nibble_lane_adder #(
    parameter int NUM_INPUTS = 4,
    parameter int SW         = 4 + $clog2(NUM_INPUTS)
) (
    input  logic [4*NUM_INPUTS-1:0] data_in,
    output logic [SW-1:0]           sum
);

    // Sum every lane nibble; SW bits cannot overflow for NUM_INPUTS lanes.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            sum = sum + SW'(data_in[4*i +: 4]);
        end
    end

endmodule

// File: rtl/accumulator_multi_sum.sv
// Nibble-serial multi-lane accumulator: sums NUM_INPUTS operands per ACCUM,
// reads the wide accumulator back a nibble per cycle, optional saturation.
module accumulator_multi_sum
    import accumulator_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int NUM_INPUTS = 4,
    parameter int GUARD_BITS = 8,
    parameter int SATURATE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [4*NUM_INPUTS-1:0] data_in,
    output logic [3:0]              data_out,
    output logic                    data_out_valid,
    output logic                    result_complete,
    output logic                    ready,
    output logic                    response,
    output logic                    overflow
);

    localparam int NIB_IN  = BIT_WIDTH / 4;
    localparam int W       = acc_width(BIT_WIDTH, NUM_INPUTS, GUARD_BITS);
    localparam int NIB_OUT = (W + 3) / 4;
    localparam int SW      = 4 + $clog2(NUM_INPUTS);
    localparam int CW      = $clog2(NIB_OUT + 1);

    state_t              state, state_nx;
    op_t                 op_q;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [W-1:0]        acc;
    logic [SW-1:0]       lane_sum;
    logic [W:0]          addend, sum_ext;
    logic                add_en, clr_en;
    logic [4*NIB_OUT-1:0] acc_pad;
    logic [3:0]          out_nib;

    nibble_lane_adder #(.NUM_INPUTS(NUM_INPUTS), .SW(SW)) u_lane_adder (
        .data_in (data_in),
        .sum     (lane_sum)
    );

    // Weight the lane sum by its nibble position; cnt is 0 in IDLE.
    assign addend  = {{(W+1-SW){1'b0}}, lane_sum} << {cnt, 2'b00};
    assign sum_ext = {1'b0, acc} + addend;
    assign acc_pad = (4*NIB_OUT)'(acc);

    assign ready    = (state == IDLE);
    assign response = (state == RECV && cnt == CW'(NIB_IN - 1)) ||
                      (state == SEND && cnt == CW'(NIB_OUT - 1));

    // Select accumulator nibble cnt for readout; bits above W-1 read as 0.
    always_comb begin
        out_nib = '0;
        for (int k = 0; k < NIB_OUT; k++) begin
            if (cnt == CW'(k)) out_nib = acc_pad[4*k +: 4];
        end
    end

    // Next-state, counter and accumulator control.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        add_en   = 1'b0;
        clr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op_t'(op))
                        ACCUM: begin
                            state_nx = RECV;
                            cnt_nx   = CW'(1);
                            add_en   = 1'b1;
                        end
                        READ_CLEAR, READ_KEEP: begin
                            state_nx = SEND;
                            cnt_nx   = '0;
                        end
                        default: state_nx = DONE;
                    endcase
                end
            end
            RECV: begin
                add_en = 1'b1;
                if (cnt == CW'(NIB_IN - 1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            SEND: begin
                if (cnt == CW'(NIB_OUT - 1)) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                clr_en   = (op_q != READ_KEEP);
            end
        endcase
    end

    // State, counter and latched operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= ACCUM;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && start) op_q <= op_t'(op);
        end
    end

    // Accumulator update with wrap or clamp, sticky overflow on carry-out.
    always_ff @(posedge clk) begin
        if (rst || clr_en) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (add_en) begin
            if (sum_ext[W]) begin
                overflow <= 1'b1;
                acc      <= (SATURATE != 0) ? {W{1'b1}} : sum_ext[W-1:0];
            end else begin
                acc <= sum_ext[W-1:0];
            end
        end
    end

    // Registered readout and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out        <= '0;
            data_out_valid  <= 1'b0;
            result_complete <= 1'b0;
        end else begin
            data_out        <= (state == SEND) ? out_nib : 4'h0;
            data_out_valid  <= (state == SEND);
            result_complete <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_accumulator_multi_sum.sv
// Directed bench for accumulator_multi_sum across four parameter sets.
module tb_accumulator_multi_sum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]      rst_v, start_v;
    logic [1:0]      op;
    logic [15:0]     din_a;
    logic [7:0]      din_b;
    logic [3:0]      din_d;
    logic [3:0][3:0] dout;
    logic [3:0]      dval, rc, rdy, resp, ovf;

    int checks   = 0;
    int failures = 0;

    // 0: defaults; 1: 8b x2 wrap; 2: 8b x2 saturate; 3: single lane
    accumulator_multi_sum u0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .op(op), .data_in(din_a),
        .data_out(dout[0]), .data_out_valid(dval[0]), .result_complete(rc[0]),
        .ready(rdy[0]), .response(resp[0]), .overflow(ovf[0]));

    accumulator_multi_sum #(.BIT_WIDTH(8), .NUM_INPUTS(2), .GUARD_BITS(0), .SATURATE(0)) u1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .op(op), .data_in(din_b),
        .data_out(dout[1]), .data_out_valid(dval[1]), .result_complete(rc[1]),
        .ready(rdy[1]), .response(resp[1]), .overflow(ovf[1]));

    accumulator_multi_sum #(.BIT_WIDTH(8), .NUM_INPUTS(2), .GUARD_BITS(0), .SATURATE(1)) u2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .op(op), .data_in(din_b),
        .data_out(dout[2]), .data_out_valid(dval[2]), .result_complete(rc[2]),
        .ready(rdy[2]), .response(resp[2]), .overflow(ovf[2]));

    accumulator_multi_sum #(.BIT_WIDTH(32), .NUM_INPUTS(1), .GUARD_BITS(8), .SATURATE(0)) u3 (
        .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .op(op), .data_in(din_d),
        .data_out(dout[3]), .data_out_valid(dval[3]), .result_complete(rc[3]),
        .ready(rdy[3]), .response(resp[3]), .overflow(ovf[3]));

    function automatic int nin(int d);
        return (d == 1 || d == 2) ? 2 : 8;
    endfunction

    function automatic int nout(int d);
        return (d == 0) ? 11 : (d == 3) ? 10 : 3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every lane gets nibble k of v.
    task automatic drive(logic [31:0] v, int k);
        logic [3:0] nib;
        nib   = v[4*k +: 4];
        din_a = {4{nib}};
        din_b = {2{nib}};
        din_d = nib;
    endtask

    task automatic accum(int d, logic [31:0] v, bit glitch);
        chk("acc_ready_idle", 64'(rdy[d]), 64'd1);
        chk("acc_resp_idle", 64'(resp[d]), 64'd0);
        start_v[d] = 1'b1;
        op = 2'b00;
        drive(v, 0);
        tick();
        for (int k = 1; k < nin(d); k++) begin
            start_v[d] = glitch;
            drive(v, k);
            chk("acc_ready_low", 64'(rdy[d]), 64'd0);
            chk("acc_resp", 64'(resp[d]), 64'(k == nin(d) - 1));
            tick();
        end
        start_v[d] = 1'b0;
        chk("acc_ready_back", 64'(rdy[d]), 64'd1);
    endtask

    task automatic read(int d, logic [1:0] o, logic [63:0] exp, bit glitch);
        bit v;
        chk("rd_ready_idle", 64'(rdy[d]), 64'd1);
        start_v[d] = 1'b1;
        op = o;
        tick();
        for (int c = 1; c <= nout(d) + 2; c++) begin
            v = (c >= 2 && c <= nout(d) + 1);
            if (glitch && c <= nout(d)) begin
                start_v[d] = 1'b1;
                op = 2'b00;
            end else begin
                start_v[d] = 1'b0;
            end
            chk("rd_resp", 64'(resp[d]), 64'(c == nout(d)));
            chk("rd_valid", 64'(dval[d]), 64'(v));
            chk("rd_data", 64'(dout[d]), v ? ((exp >> (4*(c-2))) & 64'hF) : 64'd0);
            chk("rd_complete", 64'(rc[d]), 64'(c == nout(d) + 2));
            chk("rd_ready", 64'(rdy[d]), 64'(c == nout(d) + 2));
            if (c < nout(d) + 2) tick();
        end
        start_v[d] = 1'b0;
    endtask

    task automatic clear(int d);
        chk("clr_ready_idle", 64'(rdy[d]), 64'd1);
        start_v[d] = 1'b1;
        op = 2'b11;
        tick();
        start_v[d] = 1'b0;
        chk("clr_ready_low", 64'(rdy[d]), 64'd0);
        chk("clr_complete_low", 64'(rc[d]), 64'd0);
        tick();
        chk("clr_ready_back", 64'(rdy[d]), 64'd1);
        chk("clr_complete", 64'(rc[d]), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_v   = '1;
        start_v = '0;
        op      = 2'b00;
        drive(32'h0, 0);
        tick();
        tick();
        for (int d = 0; d < 4; d++) begin
            chk("rst_ready", 64'(rdy[d]), 64'd1);
            chk("rst_valid", 64'(dval[d]), 64'd0);
            chk("rst_data", 64'(dout[d]), 64'd0);
            chk("rst_complete", 64'(rc[d]), 64'd0);
            chk("rst_overflow", 64'(ovf[d]), 64'd0);
            chk("rst_resp", 64'(resp[d]), 64'd0);
        end
        rst_v = '0;
        tick();

        // Defaults: 4 x 0xFFFFFFFF = 0x3_FFFF_FFFC
        accum(0, 32'hFFFFFFFF, 1'b0);
        read(0, 2'b10, 64'h3FFFFFFFC, 1'b0);
        chk("def_ovf", 64'(ovf[0]), 64'd0);
        read(0, 2'b01, 64'h3FFFFFFFC, 1'b0);
        read(0, 2'b10, 64'h0, 1'b0);

        // start held high during RECV and SEND is ignored: 4 x 0x11111111
        accum(0, 32'h11111111, 1'b1);
        read(0, 2'b10, 64'h44444444, 1'b1);
        read(0, 2'b10, 64'h44444444, 1'b0);

        // Reset while SEND is on nibble 4
        start_v[0] = 1'b1;
        op = 2'b10;
        tick();
        start_v[0] = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        chk("mid_valid_pre", 64'(dval[0]), 64'd1);
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        chk("mid_ready", 64'(rdy[0]), 64'd1);
        chk("mid_valid", 64'(dval[0]), 64'd0);
        chk("mid_data", 64'(dout[0]), 64'd0);
        chk("mid_resp", 64'(resp[0]), 64'd0);
        tick();
        read(0, 2'b10, 64'h0, 1'b0);

        // W=9 wrap: 2 x (0xFF+0xFF) = 0x3FC -> 0x1FC
        accum(1, 32'hFF, 1'b0);
        accum(1, 32'hFF, 1'b0);
        read(1, 2'b10, 64'h1FC, 1'b0);
        chk("wrap_ovf", 64'(ovf[1]), 64'd1);
        clear(1);
        chk("wrap_ovf_clr", 64'(ovf[1]), 64'd0);
        read(1, 2'b10, 64'h0, 1'b0);

        // W=9 saturate: clamps to 0x1FF
        accum(2, 32'hFF, 1'b0);
        accum(2, 32'hFF, 1'b0);
        read(2, 2'b10, 64'h1FF, 1'b0);
        chk("sat_ovf", 64'(ovf[2]), 64'd1);
        clear(2);
        chk("sat_ovf_clr", 64'(ovf[2]), 64'd0);

        // Single lane, 1 accumulated three times
        accum(3, 32'h1, 1'b0);
        accum(3, 32'h1, 1'b0);
        accum(3, 32'h1, 1'b0);
        read(3, 2'b10, 64'h3, 1'b0);
        chk("one_ovf", 64'(ovf[3]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
